// File: rtl/bound_scan_512bit_pkg.sv
// Shared types and constants for the 512-bit row bound scanner.
// Holds FSM encoding, row geometry and mask-side constants.
package bound_scan_512bit_pkg;

  localparam int ROW_BITS  = 512;
  localparam int WORD_BITS = 32;
  localparam int IDX_W     = 9;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MASK_L,
    MASK_R,
    DONE
  } state_t;

endpackage

// File: rtl/prio_enc_32.sv
// Combinational lowest/highest set-bit encoder for one 32-bit word.
// Ports: word in; low, high (5-bit positions) and nz (word non-zero) out.
module prio_enc_32 (
  input  logic [31:0] word,
  output logic [4:0]  low,
  output logic [4:0]  high,
  output logic        nz
);

  always_comb begin
    low  = '0;
    high = '0;
    nz   = |word;
    for (int i = 31; i >= 0; i--) begin
      if (word[i]) low = 5'(i);
    end
    for (int i = 0; i < 32; i++) begin
      if (word[i]) high = 5'(i);
    end
  end

endmodule

// File: rtl/bound_scan_512bit.sv
// Scans one 512-bit row from BRAM for its lowest/highest set pixel,
// then requests left and right edge masks from mask_gen_512bit.
// Ports: i_clk, i_rstn, i_start, BRAM read port (o_bram_en/addr,
// i_bram_rdata), results (o_found, o_low_idx, o_high_idx, o_done,
// o_busy), mask handshake (o_mg_trig, o_mg_left_or_right,
// o_mg_bound_index, i_mg_done).
module bound_scan_512bit
  import bound_scan_512bit_pkg::*;
#(
  parameter int WORDS  = 16,
  parameter int RD_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_bram_en,
  output logic [3:0]       o_bram_addr,
  input  logic [31:0]      i_bram_rdata,
  output logic             o_found,
  output logic [IDX_W-1:0] o_low_idx,
  output logic [IDX_W-1:0] o_high_idx,
  output logic             o_mg_trig,
  output logic             o_mg_left_or_right,
  output logic [IDX_W-1:0] o_mg_bound_index,
  input  logic             i_mg_done,
  output logic             o_done
);

  localparam logic [4:0] LAT_C   = 5'(RD_LAT);
  localparam logic [4:0] WORDS_C = 5'(WORDS);
  localparam logic [4:0] EXIT_C  = 5'(WORDS + RD_LAT - 1);

  state_t state;
  logic [4:0] cnt;
  logic       ph;

  logic [4:0] lo5;
  logic [4:0] hi5;
  logic       nz;

  prio_enc_32 u_enc (
    .word (i_bram_rdata),
    .low  (lo5),
    .high (hi5),
    .nz   (nz)
  );

  // cnt counts FETCH cycles from 0; data for word (cnt - RD_LAT)
  // is on the bus once cnt reaches RD_LAT.
  logic             take;
  logic [3:0]       widx;
  logic             found_n;
  logic [IDX_W-1:0] low_n;
  logic [IDX_W-1:0] high_n;
  logic [IDX_W-1:0] lbound;
  logic [4:0]       cnt_inc;

  assign take    = (state == FETCH) && (cnt >= LAT_C);
  assign widx    = 4'(cnt - LAT_C);
  assign cnt_inc = cnt + 5'd1;
  assign lbound  = 9'(ROW_BITS - 1) - high_n;

  always_comb begin
    found_n = o_found;
    low_n   = o_low_idx;
    high_n  = o_high_idx;
    if (take && nz) begin
      if (!o_found) low_n = {widx, lo5};
      high_n  = {widx, hi5};
      found_n = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state              <= IDLE;
      cnt                <= '0;
      ph                 <= 1'b0;
      o_busy             <= 1'b0;
      o_bram_en          <= 1'b0;
      o_bram_addr        <= '0;
      o_found            <= 1'b0;
      o_low_idx          <= '0;
      o_high_idx         <= '0;
      o_mg_trig          <= 1'b0;
      o_mg_left_or_right <= 1'b0;
      o_mg_bound_index   <= '0;
      o_done             <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            state       <= FETCH;
            o_busy      <= 1'b1;
            o_bram_en   <= 1'b1;
            o_bram_addr <= '0;
            cnt         <= '0;
            o_found     <= 1'b0;
            o_low_idx   <= '0;
            o_high_idx  <= '0;
          end
        end
        FETCH: begin
          cnt         <= cnt_inc;
          o_bram_en   <= cnt_inc < WORDS_C;
          o_bram_addr <= (cnt_inc < WORDS_C) ? 4'(cnt_inc) : 4'd0;
          o_found     <= found_n;
          o_low_idx   <= low_n;
          o_high_idx  <= high_n;
          if (cnt == EXIT_C) begin
            ph <= 1'b0;
            if (!found_n) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state              <= MASK_L;
              o_mg_left_or_right <= LEFT;
              o_mg_bound_index   <= lbound;
            end
          end
        end
        MASK_L: begin
          // A zero bound, or a completed handshake, moves on to the
          // right side with the low index as its bound.
          if ((!ph && o_mg_bound_index == '0) || (ph && i_mg_done)) begin
            state              <= MASK_R;
            ph                 <= 1'b0;
            o_mg_trig          <= 1'b0;
            o_mg_left_or_right <= RIGHT;
            o_mg_bound_index   <= o_low_idx;
          end else if (!ph && !i_mg_done) begin
            o_mg_trig <= 1'b1;
            ph        <= 1'b1;
          end
        end
        MASK_R: begin
          if ((!ph && o_mg_bound_index == '0) || (ph && i_mg_done)) begin
            state     <= DONE;
            ph        <= 1'b0;
            o_mg_trig <= 1'b0;
            o_done    <= 1'b1;
          end else if (!ph && !i_mg_done) begin
            o_mg_trig <= 1'b1;
            ph        <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
